// File: rtl/fp_posit_mul.sv
// fp_posit_mul: FP16 activation times bit-serial posit (es=0) weight, unnormalised product
module fp_posit_mul #(
  parameter int ACT_WIDTH = 16,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACT_WIDTH-1:0]   act,
  input  logic                   w,
  input  logic                   valid,
  input  logic                   set,
  input  logic [3:0]             precision,
  output logic                   sign_out,
  output logic [EXP_WIDTH-1:0]   exp_out,
  output logic [MAN_WIDTH+3:0]   mantissa_out,
  output logic                   done
);
  logic [3:0] prec_q, prec_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] col_q, col_d;
  logic done_q, done_d, sign_q, sign_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [MAN_WIDTH+3:0] man_q, man_d;
  logic [7:0] shifted, raw, al;
  logic [6:0] vm;
  logic [3:0] m;
  logic [1:0] fb;
  logic [2:0] wm;
  logic run, s, r, special, last;
  logic [MAN_WIDTH:0] am;
  logic [EXP_WIDTH-1:0] ae, dec_exp;
  logic [MAN_WIDTH+3:0] dec_man;
  // Decode the completed weight word, left-aligned so the sign sits at bit 7 for every width
  always_comb begin
    shifted = {col_q[6:0], w};
    raw = shifted << (4'd8 - prec_q);
    s = raw[7];
    al = s ? 8'(-raw) : raw;
    special = (raw == 8'h00) || (raw == 8'h80);
    vm = 7'h7f << (4'd8 - prec_q);
    r = al[6];
    m = 4'd0;
    run = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      if (run && vm[i] && (al[i] == r)) m = m + 4'd1;
      else run = 1'b0;
    end
    fb = 2'((al << (m + 4'd2)) >> 6);
    wm = (m + 4'd2 >= prec_q) ? 3'b001 : (m + 4'd3 == prec_q) ? {2'b01, fb[1]} : {1'b1, fb};
    ae = act[ACT_WIDTH-2:MAN_WIDTH];
    am = {|ae, act[MAN_WIDTH-1:0]};
    dec_exp = r ? ae + EXP_WIDTH'(m) - EXP_WIDTH'(1) : ae - EXP_WIDTH'(m);
    dec_man = (MAN_WIDTH+4)'(am) * (MAN_WIDTH+4)'(wm);
  end
  // Next-state: precision load/abort, serial collection and result capture on the final bit
  always_comb begin
    prec_d = prec_q;
    cnt_d = cnt_q;
    col_d = col_q;
    done_d = 1'b0;
    sign_d = sign_q;
    exp_d = exp_q;
    man_d = man_q;
    last = ({1'b0, cnt_q} == prec_q - 4'd1);
    if (set) begin
      prec_d = (precision < 4'd3) ? 4'd3 : (precision > 4'd8) ? 4'd8 : precision;
      cnt_d = 3'd0;
      col_d = 8'd0;
    end else if (valid) begin
      col_d = shifted;
      cnt_d = last ? 3'd0 : cnt_q + 3'd1;
      if (last) begin
        done_d = 1'b1;
        sign_d = special ? 1'b0 : act[ACT_WIDTH-1] ^ s;
        exp_d = special ? '0 : dec_exp;
        man_d = special ? '0 : dec_man;
      end
    end
  end
  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prec_q <= 4'd4;
      cnt_q <= 3'd0;
      col_q <= 8'd0;
      done_q <= 1'b0;
      sign_q <= 1'b0;
      exp_q <= '0;
      man_q <= '0;
    end else begin
      prec_q <= prec_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      done_q <= done_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      man_q <= man_d;
    end
  end
  assign done = done_q;
  assign sign_out = sign_q;
  assign exp_out = exp_q;
  assign mantissa_out = man_q;
endmodule

// File: tb/tb_fp_posit_mul.sv
// tb_fp_posit_mul: directed table vectors plus stall, abort, hold and reset sequences
module tb_fp_posit_mul;
  logic clk, rst, w, valid, set, sign_out, done;
  logic [15:0] act;
  logic [3:0] precision;
  logic [4:0] exp_out;
  logic [13:0] mantissa_out;
  int tests, fails;
  typedef struct {
    logic [15:0] a;
    logic [7:0] wd;
    logic [3:0] p;
    int n;
    logic s;
    logic [4:0] e;
    logic [13:0] m;
  } vec_t;
  vec_t tv[16];
  fp_posit_mul dut (
    .clk(clk), .rst(rst), .act(act), .w(w), .valid(valid), .set(set),
    .precision(precision), .sign_out(sign_out), .exp_out(exp_out),
    .mantissa_out(mantissa_out), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic set_prec(input logic [3:0] p);
    set = 1'b1;
    precision = p;
    valid = 1'b1;
    w = 1'b1;
    @(negedge clk);
    set = 1'b0;
    valid = 1'b0;
    chk("set_done", done, 0);
  endtask
  task automatic send(input logic [15:0] a, input logic [7:0] wd, input int n, input int st,
                      input int sl, input logic es, input logic [4:0] ee, input logic [13:0] em);
    for (int i = 0; i < n; i++) begin
      if (i == st) begin
        valid = 1'b0;
        repeat (sl) begin
          @(negedge clk);
          chk("stall_done", done, 0);
        end
      end
      valid = 1'b1;
      w = wd[n-1-i];
      act = (i == n - 1) ? a : ~a;
      @(negedge clk);
      if (i < n - 1) chk("mid_done", done, 0);
    end
    valid = 1'b0;
    chk("done", done, 1);
    chk("sign", sign_out, es);
    chk("exp", exp_out, ee);
    chk("man", mantissa_out, em);
  endtask
  initial begin
    tests = 0;
    fails = 0;
    tv[0]  = '{16'h1234, 8'h03, 4'd4, 4, 1'b0, 5'h03, 14'h129c};
    tv[1]  = '{16'hf234, 8'h03, 4'd4, 4, 1'b1, 5'h1b, 14'h129c};
    tv[2]  = '{16'hf234, 8'h04, 4'd4, 4, 1'b1, 5'h1c, 14'h0c68};
    tv[3]  = '{16'hf234, 8'h0c, 4'd4, 4, 1'b0, 5'h1c, 14'h0c68};
    tv[4]  = '{16'h1234, 8'h00, 4'd4, 4, 1'b0, 5'h00, 14'h0000};
    tv[5]  = '{16'h1234, 8'h08, 4'd4, 4, 1'b0, 5'h00, 14'h0000};
    tv[6]  = '{16'h3c00, 8'h40, 4'd15, 8, 1'b0, 5'h0f, 14'h1000};
    tv[7]  = '{16'h3c00, 8'h7f, 4'd15, 8, 1'b0, 5'h15, 14'h0400};
    tv[8]  = '{16'h3c00, 8'h01, 4'd15, 8, 1'b0, 5'h09, 14'h0400};
    tv[9]  = '{16'h3c00, 8'h5a, 4'd15, 8, 1'b0, 5'h0f, 14'h1c00};
    tv[10] = '{16'h0001, 8'h40, 4'd15, 8, 1'b0, 5'h00, 14'h0004};
    tv[11] = '{16'h3c00, 8'hc0, 4'd15, 8, 1'b1, 5'h0f, 14'h1000};
    tv[12] = '{16'h0400, 8'h01, 4'd15, 8, 1'b0, 5'h1b, 14'h0400};
    tv[13] = '{16'h3c00, 8'h03, 4'd0, 3, 1'b0, 5'h10, 14'h0400};
    tv[14] = '{16'h3c00, 8'h02, 4'd0, 3, 1'b0, 5'h0f, 14'h0400};
    tv[15] = '{16'h3c00, 8'h06, 4'd0, 3, 1'b1, 5'h0f, 14'h0400};
    rst = 1'b1;
    set = 1'b0;
    valid = 1'b0;
    w = 1'b0;
    act = 16'h0;
    precision = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_done", done, 0);
    chk("rst_sign", sign_out, 0);
    chk("rst_exp", exp_out, 0);
    chk("rst_man", mantissa_out, 0);
    set_prec(4'd4);
    for (int i = 0; i < 16; i++) begin
      if (i == 6 || i == 13) set_prec(tv[i].p);
      send(tv[i].a, tv[i].wd, tv[i].n, -1, 0, tv[i].s, tv[i].e, tv[i].m);
    end
    set_prec(4'd4);
    send(16'h1234, 8'h03, 4, 2, 3, 1'b0, 5'h03, 14'h129c);
    repeat (2) @(negedge clk);
    chk("hold_done", done, 0);
    chk("hold_sign", sign_out, 0);
    chk("hold_exp", exp_out, 5'h03);
    chk("hold_man", mantissa_out, 14'h129c);
    valid = 1'b1;
    w = 1'b0;
    @(negedge clk);
    w = 1'b1;
    @(negedge clk);
    chk("abort_pre", done, 0);
    set_prec(4'd4);
    @(negedge clk);
    chk("abort_idle", done, 0);
    send(16'hf234, 8'h04, 4, -1, 0, 1'b1, 5'h1c, 14'h0c68);
    set_prec(4'd15);
    valid = 1'b1;
    w = 1'b0;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_done", done, 0);
    chk("rst2_sign", sign_out, 0);
    chk("rst2_exp", exp_out, 0);
    chk("rst2_man", mantissa_out, 0);
    send(16'h1234, 8'h03, 4, -1, 0, 1'b0, 5'h03, 14'h129c);
    @(negedge clk);
    chk("pulse_end", done, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_posit_mul.md
Name: fp_posit_mul

Overview:
- Multiplies an FP16 activation by a posit weight that arrives bit-serially, MSB first, one bit per clock.
- Produces an unnormalised product as sign, exponent and integer mantissa, qualified by a one-cycle done pulse.
- Sits in the FP-activation × posit-weight MAC datapath, ahead of the accumulator and normaliser.

Parameters:
- ACT_WIDTH, 16, activation width (1 sign + EXP_WIDTH + MAN_WIDTH).
- EXP_WIDTH, 5, activation exponent field width (biased, bias not removed).
- MAN_WIDTH, 10, activation fraction field width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- act  in  ACT_WIDTH  FP16 activation; sampled in the cycle the last weight bit is taken.
- w  in  1  serial weight bit, MSB (posit sign) first.
- valid  in  1  w is meaningful this cycle.
- set  in  1  load precision.
- precision  in  4  posit width n, legal range 3..8.
- sign_out  out  1  product sign.
- exp_out  out  EXP_WIDTH  act exponent + posit scale.
- mantissa_out  out  MAN_WIDTH+4 (14)  act significand × weight significand.
- done  out  1  one-cycle result strobe.

Behaviour:
- Reset (rst=1 at a clock edge) clears the following, overriding all other inputs:
  - done=0, sign_out=0, exp_out=0, mantissa_out=0.
  - bit counter=0, collect register=0.
  - precision register=4.
- Precision register:
  - When set=1, latch precision, clamped: values <3 become 3, values >8 become 8.
  - set also aborts any partial weight (counter=0, partial bits discarded).
  - When set and valid are both 1, set wins and w is ignored that cycle.
- Weight collection:
  - Each cycle with valid=1 and set=0, shift w into an 8-bit collect register and increment the counter.
  - valid=0 stalls collection: counter and register hold, no timeout.
  - When the bit taken is bit number n (counter==n-1), sample act in that same cycle and decode.
  - Results register at that edge, so done=1 is visible the following cycle for exactly one cycle.
  - The counter returns to 0 at that edge, so the next weight's first bit may arrive the very next cycle (back-to-back streams, one result per n valid cycles).
  - Outputs hold their last values until the next done.
- Posit decode (es=0, width n):
  - Sign s = first bit.
  - If s=1, two's-complement the n-bit word before decoding the magnitude.
  - Regime is a run of m identical bits r after the sign, ended by the opposite bit or by end of word.
  - Scale k = m-1 if r=1; k = -m if r=0.
  - Remaining bits are the fraction f. Keep the top 2 bits; drop the rest (truncate).
  - Weight significand wm (3 bits, right-aligned): 0 fraction bits gives 001; 1 bit gives {01,f1}; 2 or more bits give {1,f1,f0}.
- Special weight values:
  - Word all zeros (zero): result mantissa_out=0, exp_out=0, sign_out=0, done still pulses.
  - Word 1 followed by all zeros (NaR): same as zero.
- Activation:
  - as = act[15]; ae = act[14:10].
  - Significand am = {hidden, act[9:0]} with hidden = (ae != 0).
  - No special handling of Inf/NaN.
- Result:
  - sign_out = as XOR s.
  - exp_out = ae + k, computed modulo 2^5 (wraps, no saturation).
  - mantissa_out = am × wm (11b × 3b = 14b, exact, not normalised).

Test Plan:
- Reset, set=1 with precision=4, then act=0x1234 and serial w=0,0,1,1 (0.75) with valid=1 → one cycle after the 4th bit: done=1, sign_out=0, exp_out=00011, mantissa_out=0x129C.
- Back-to-back stream: act=0xF234, w=0,0,1,1 immediately after the previous weight → done one cycle after its last bit, sign_out=1, exp_out=11011, mantissa_out=0x129C. No idle cycle is required between weights.
- act=0xF234, w=0,1,0,0 (1.0) → sign_out=1, exp_out=11100, mantissa_out=0x0C68. Then w=1,1,0,0 (-1.0) → sign_out=0, exp_out=11100, mantissa_out=0x0C68.
- Stall: deassert valid for 3 cycles between bits 2 and 3 of a 0,0,1,1 stream → identical result to the unstalled case; done occurs exactly 1 cycle after the final valid bit.
- Zero and abort:
  - w=0,0,0,0 → done=1 with all outputs 0.
  - set=1 pulsed after 2 bits of a stream → no done; the next full 4-bit stream decodes correctly.
- Precision clamp and reset mid-stream:
  - precision=15 latched → 8 bits consumed per result.
  - rst=1 mid-stream → outputs 0, precision back to 4, partial stream lost.
